// File: rtl/vt_pkg.sv
`timescale 1ns/1ps
// Shared Varshamov-Tenengolts definitions: status codes, residue width and
// the data-position map used by both the encoder and the stream decoder.
package vt_pkg;

    typedef enum logic [1:0] {
        VT_OK    = 2'b00,
        VT_FIXED = 2'b01,
        VT_FAIL  = 2'b10
    } vt_status_e;

    function automatic int unsigned vt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic bit is_pow2(input int unsigned p);
        return (p != 0) && ((p & (p - 1)) == 0);
    endfunction

    // 1-based codeword position of data bit j (j-th non-power-of-two position).
    function automatic int unsigned data_pos(input int unsigned j);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned p = 1; p < 256; p++) begin
            if (pos == 0 && !is_pow2(p)) begin
                if (cnt == j) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/vt_syndrome_acc.sv
`timescale 1ns/1ps
// Serial accumulator of the VT weighted sum (mod n+1) and the Hamming weight
// of the word currently being received.
module vt_syndrome_acc #(
    parameter int unsigned n = 10,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] pos,
    input  logic         bit_in,
    output logic [W-1:0] syndrome_nxt,
    output logic [W-1:0] weight
);
    localparam logic [W:0] MOD = (W+1)'(n + 1);

    logic [W-1:0] syndrome;
    logic [W:0]   sum;

    // Both operands are below n+1, so one conditional subtract keeps the residue reduced.
    always_comb begin
        sum = {1'b0, syndrome} + (bit_in ? {1'b0, pos} : '0);
        if (sum >= MOD) sum = sum - MOD;
        syndrome_nxt = sum[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            syndrome <= '0;
            weight   <= '0;
        end else if (en) begin
            syndrome <= syndrome_nxt;
            weight   <= weight + W'(bit_in);
        end
    end

endmodule

// File: rtl/vt_stream_decode.sv
`timescale 1ns/1ps
// Bit-serial VT decoder: collects one received word, checks its residue, repairs
// a single deletion by scanning one gap per cycle, then presents data and status.
module vt_stream_decode
    import vt_pkg::*;
#(
    parameter int unsigned n            = 10,
    parameter int unsigned k            = 5,
    parameter int unsigned SYNDROME_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [k-1:0] out_data,
    output logic [1:0]   out_status
);
    localparam int unsigned  W   = vt_width(n);
    localparam int unsigned  IW  = (n > 1) ? $clog2(n) : 1;
    localparam int unsigned  KW  = (k > 1) ? $clog2(k) : 1;
    localparam logic [W-1:0] A   = W'(SYNDROME_VAL);
    localparam logic [W:0]   MOD = (W+1)'(n + 1);

    typedef enum logic [1:0] {RECV, CORRECT, OUT} state_e;

    state_e       state, state_nxt;
    vt_status_e   status_q, status_nxt;
    logic [W-1:0] count, g, ones, delta, delta_nxt;
    logic [W-1:0] syndrome_nxt, weight;
    logic [n-1:0] word, word_full, fixed, lo_mask;
    logic [W:0]   diff;
    logic [k-1:0] data_q, data_nxt;
    logic         accept, word_end, handshake, hit, ins, load_out;

    function automatic logic [k-1:0] extract(input logic [n-1:0] w);
        logic [k-1:0] d;
        d = '0;
        for (int unsigned j = 0; j < k; j++) d[KW'(j)] = w[IW'(data_pos(j) - 1)];
        return d;
    endfunction

    vt_syndrome_acc #(.n(n), .W(W)) u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (handshake),
        .en           (accept),
        .pos          (count + W'(1)),
        .bit_in       (in_bit),
        .syndrome_nxt (syndrome_nxt),
        .weight       (weight)
    );

    always_comb begin
        accept    = in_valid && (state == RECV);
        word_end  = accept && (in_last || count == W'(n - 1));
        handshake = (state == OUT) && out_ready;
        word_full = word;
        word_full[IW'(count)] = in_bit;
        diff = {1'b0, A} - {1'b0, syndrome_nxt};
        if (syndrome_nxt > A) diff = diff + MOD;
        delta_nxt = diff[W-1:0];
        // Gap g: ones_left tracks how many received ones sit left of the gap.
        if (delta <= weight) begin
            ins = 1'b0;
            hit = (weight - ones) == delta;
        end else begin
            ins = 1'b1;
            hit = (g - ones) == (delta - weight - W'(1));
        end
        lo_mask = (n'(1) << g) - n'(1);
        fixed   = (word & lo_mask) | ((word << 1) & ~lo_mask & ~(n'(1) << g)) | (n'(ins) << g);
    end

    always_comb begin
        state_nxt  = state;
        load_out   = 1'b0;
        status_nxt = VT_FAIL;
        data_nxt   = '0;
        case (state)
            RECV: begin
                if (word_end) begin
                    if (count == W'(n - 1)) begin
                        load_out  = 1'b1;
                        state_nxt = OUT;
                        if (syndrome_nxt == A) begin
                            status_nxt = VT_OK;
                            data_nxt   = extract(word_full);
                        end
                    end else if (count == W'(n - 2)) begin
                        state_nxt = CORRECT;
                    end else begin
                        load_out  = 1'b1;
                        state_nxt = OUT;
                    end
                end
            end
            CORRECT: begin
                if (hit) begin
                    load_out   = 1'b1;
                    state_nxt  = OUT;
                    status_nxt = VT_FIXED;
                    data_nxt   = extract(fixed);
                end else if (g == W'(n - 1)) begin
                    load_out  = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_nxt = RECV;
            end
            default: state_nxt = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RECV;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            g        <= '0;
            ones     <= '0;
            delta    <= '0;
            word     <= '0;
            data_q   <= '0;
            status_q <= VT_OK;
        end else begin
            if (accept) begin
                word  <= word_full;
                count <= count + W'(1);
            end
            if (handshake) count <= '0;
            if (word_end) begin
                delta <= delta_nxt;
                g     <= '0;
                ones  <= '0;
            end
            if (state == CORRECT) begin
                g    <= g + W'(1);
                ones <= ones + W'(word[IW'(g)]);
            end
            if (load_out) begin
                data_q   <= data_nxt;
                status_q <= status_nxt;
            end
        end
    end

    assign in_ready   = (state == RECV);
    assign out_valid  = (state == OUT);
    assign out_data   = data_q;
    assign out_status = status_q;

endmodule

// File: tb/tb_vt_stream_decode.sv
`timescale 1ns/1ps
// Directed bench for vt_stream_decode: brute-force VT insertion model feeding an
// expectation queue, checked by a per-cycle compare process on the output side.
module tb_vt_stream_decode;
    localparam int N = 10;
    localparam int K = 5;
    localparam int A = 0;

    localparam logic [N-1:0] CLEAN = 10'b0010000100;  // positions 3,8
    localparam logic [N-1:0] DEL1  = 10'b0001000000;  // 9 bits, position 7
    localparam logic [N-1:0] DEL0  = 10'b0001000100;  // 9 bits, positions 3,7
    localparam logic [N-1:0] BAD   = 10'b0010000101;  // positions 1,3,8
    localparam logic [N-1:0] CW2   = 10'b0101110111;  // positions 1,2,3,5,6,7,9
    localparam logic [N-1:0] CW3   = 10'b1000000001;  // positions 1,10

    logic clk = 0, rst_n = 0, in_valid = 0, in_bit = 0, in_last = 0, out_ready = 1;
    logic in_ready, out_valid;
    logic [K-1:0] out_data;
    logic [1:0] out_status;

    int checks = 0, passes = 0, cyc = 0;

    typedef struct {
        logic [1:0]   st;
        logic [K-1:0] data;
        int           lat;
        int           hold;
        int           t_last;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    bit   active = 0, skip = 0;
    int   vcnt = 0, bp = 0;

    vt_stream_decode #(.n(N), .k(K), .SYNDROME_VAL(A)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_status (out_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: event did not occur within its bound", name);
    endtask

    function automatic int vt_res(input logic [N-1:0] w, input int len);
        int s = 0;
        for (int i = 0; i < len; i++) if (w[i]) s += i + 1;
        return s % (N + 1);
    endfunction

    function automatic logic [K-1:0] extract(input logic [N-1:0] w);
        logic [K-1:0] d = '0;
        int j = 0;
        for (int p = 1; p <= N; p++)
            if ((p & (p - 1)) != 0 && j < K) begin
                d[j] = w[p-1];
                j++;
            end
        return d;
    endfunction

    function automatic logic [N-1:0] insert_bit(input logic [N-1:0] rx, input int g, input logic b);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (i < g) ? rx[i] : (i == g) ? b : rx[i-1];
        return r;
    endfunction

    function automatic logic [N-1:0] delete_bit(input logic [N-1:0] w, input int p);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N - 1; i++) r[i] = (i < p) ? w[i] : w[i+1];
        return r;
    endfunction

    // Result of a received word: try every single-bit insertion, the VT property
    // makes the repaired codeword unique; latency is the leftmost working gap + 1.
    function automatic void model(input logic [N-1:0] rx, input int len,
                                  output logic [1:0] st, output logic [K-1:0] d, output int lat);
        logic [N-1:0] cand;
        bit found = 0;
        st = 2'b10; d = '0; lat = 0;
        if (len == N) begin
            if (vt_res(rx, N) == A) begin
                st = 2'b00;
                d  = extract(rx);
            end
        end else if (len == N - 1) begin
            lat = N;
            for (int g = 0; g < N; g++)
                for (int b = 0; b < 2; b++)
                    if (!found) begin
                        cand = insert_bit(rx, g, b != 0);
                        if (vt_res(cand, N) == A) begin
                            found = 1;
                            st  = 2'b01;
                            d   = extract(cand);
                            lat = g + 1;
                        end
                    end
        end
    endfunction

    task automatic send_word(input logic [N-1:0] w, input int len, input bit use_last,
                             input bit expect_out, input int hold);
        logic [1:0]   st;
        logic [K-1:0] d;
        int           lat, t;
        exp_t         e;
        model(w, len, st, d, lat);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            in_valid = 1;
            in_bit   = w[i];
            in_last  = use_last && (i == len - 1);
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                fail("in_ready_wait");
                in_valid = 0;
                in_last  = 0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        in_last  = 0;
        if (expect_out) begin
            e.st = st; e.data = d; e.lat = lat; e.hold = hold; e.t_last = cyc;
            expq.push_back(e);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0; vcnt = 0; bp = 0; out_ready = 1;
            end else if (out_valid) begin
                check("in_ready_during_out", in_ready, 0);
                if (!active) begin
                    active = 1;
                    vcnt   = 0;
                    if (expq.size() == 0) begin
                        fail("unexpected_out_valid");
                        skip = 1;
                        bp   = 0;
                    end else begin
                        cur  = expq.pop_front();
                        skip = 0;
                        bp   = cur.hold;
                        check("status", out_status, cur.st);
                        check("data", out_data, cur.data);
                        check("latency", cyc - cur.t_last, cur.lat);
                    end
                end else if (!skip) begin
                    check("hold_status", out_status, cur.st);
                    check("hold_data", out_data, cur.data);
                end
                vcnt++;
                if (bp > 0) begin
                    out_ready = 0;
                    bp--;
                end else begin
                    out_ready = 1;
                end
            end else begin
                if (active && !skip) check("valid_cycles", vcnt, cur.hold + 1);
                active = 0;
                vcnt   = 0;
                out_ready = 1;
            end
        end
    end

    initial begin : stimulus
        logic [1:0]   st;
        logic [K-1:0] d;
        int           lat, t;

        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_status", out_status, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1;

        model(CLEAN, 10, st, d, lat);
        check("model_clean", {st, d, 8'(lat)}, {2'b00, 5'b00001, 8'd0});
        model(DEL1, 9, st, d, lat);
        check("model_del1", {st, d, 8'(lat)}, {2'b01, 5'b00001, 8'd3});
        model(DEL0, 9, st, d, lat);
        check("model_del0", {st, d, 8'(lat)}, {2'b01, 5'b00001, 8'd4});
        model(BAD, 10, st, d, lat);
        check("model_bad", {st, d}, {2'b10, 5'b00000});
        model(CW2, 10, st, d, lat);
        check("model_cw2", {st, d}, {2'b00, 5'b11111});

        send_word(CLEAN, 10, 1, 1, 0);
        send_word(DEL1, 9, 1, 1, 0);
        send_word(DEL0, 9, 1, 1, 0);
        send_word(BAD, 10, 1, 1, 0);
        send_word(CLEAN, 10, 1, 1, 5);
        send_word(CLEAN, 7, 1, 1, 0);
        send_word(CLEAN, 10, 0, 1, 0);
        send_word(CW2, 10, 1, 1, 2);
        send_word(CW3, 1, 1, 1, 0);
        for (int p = 0; p < N; p++) send_word(delete_bit(CW2, p), 9, 1, 1, 0);
        for (int p = 0; p < N; p++) send_word(delete_bit(CW3, p), 9, 1, 1, 0);

        send_word(DEL0, 9, 1, 0, 0);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        check("midword_rst_out_valid", out_valid, 0);
        check("midword_rst_in_ready", in_ready, 1);
        check("midword_rst_out_data", out_data, 0);
        check("midword_rst_out_status", out_status, 0);
        rst_n = 1;
        send_word(CLEAN, 10, 1, 1, 0);

        t = 0;
        while ((expq.size() != 0 || active) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (expq.size() != 0 || active) fail("drain_outputs");
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
